// File: rtl/hdmi_pixel_fifo.sv
// Pixel buffer and frame aligner feeding the HDMI encoder.
// Buffers a valid/ready RGB888 stream tagged with start-of-frame, hunts for a
// frame start, then releases pixels first-word-fall-through on the display
// read strobe. Underflow or a misplaced SOF drops back to hunting and blanks
// the output until the next aligned frame start.
module hdmi_pixel_fifo #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned AW       = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned THRESH   = 512
) (
    input  logic          i_pixclk,
    input  logic          i_reset_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_sof,
    input  logic [7:0]    i_red,
    input  logic [7:0]    i_grn,
    input  logic [7:0]    i_blu,
    input  logic          i_rd,
    input  logic          i_newframe,
    output logic [7:0]    o_red,
    output logic [7:0]    o_grn,
    output logic [7:0]    o_blu,
    output logic [AW:0]   o_level,
    output logic          o_synced,
    output logic          o_underflow,
    output logic          o_frame_err
);

    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    typedef struct packed {
        logic       sof;
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } pix_t;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    pix_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   pix_cnt;
    logic [CW-1:0]   pix_cnt_nxt;
    logic            wr_en;
    logic            pop;
    logic            empty;
    logic            underflow_nxt;
    logic            frame_err_nxt;
    logic [23:0]     rgb_out;
    pix_t            head;

    assign empty    = (o_level == '0);
    assign o_ready  = (o_level != (AW+1)'(DEPTH));
    assign wr_en    = i_valid && o_ready;
    assign head     = mem[rd_ptr];
    assign o_synced = (state == RUN);
    assign o_red    = rgb_out[23:16];
    assign o_grn    = rgb_out[15:8];
    assign o_blu    = rgb_out[7:0];

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge i_pixclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{sof: i_sof, red: i_red, grn: i_grn, blu: i_blu};
        end
    end

    // Alignment decisions: discard in HUNT, checked release in RUN.
    always_comb begin
        state_nxt     = state;
        pix_cnt_nxt   = pix_cnt;
        pop           = 1'b0;
        underflow_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        rgb_out       = 24'h000000;
        case (state)
            HUNT: begin
                if (!empty && !head.sof) begin
                    pop = 1'b1;
                end else if (i_newframe && !empty && head.sof &&
                             (o_level >= (AW+1)'(THRESH))) begin
                    state_nxt   = RUN;
                    pix_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (i_rd) begin
                    if (empty) begin
                        underflow_nxt = 1'b1;
                        state_nxt     = HUNT;
                    end else if (head.sof != (pix_cnt == '0)) begin
                        // Head is kept so a SOF entry can start the next lock.
                        frame_err_nxt = 1'b1;
                        state_nxt     = HUNT;
                    end else begin
                        rgb_out = {head.red, head.grn, head.blu};
                        pop     = 1'b1;
                        if (pix_cnt == CW'(FRAME_PIX - 1)) begin
                            pix_cnt_nxt = '0;
                        end else begin
                            pix_cnt_nxt = pix_cnt + CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // State, frame position and status pulses.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= HUNT;
            pix_cnt     <= '0;
            o_underflow <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pix_cnt     <= pix_cnt_nxt;
            o_underflow <= underflow_nxt;
            o_frame_err <= frame_err_nxt;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   o_level <= o_level + (AW+1)'(1);
                2'b01:   o_level <= o_level - (AW+1)'(1);
                default: o_level <= o_level;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_pixel_fifo.sv
// Bench for hdmi_pixel_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hdmi_pixel_fifo;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int H      = 4;
    localparam int V      = 2;
    localparam int FRAME  = H * V;
    localparam int THRESH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_sof = 1'b0;
    logic [7:0]    i_red = 8'h00;
    logic [7:0]    i_grn = 8'h00;
    logic [7:0]    i_blu = 8'h00;
    logic          i_rd = 1'b0;
    logic          i_newframe = 1'b0;
    logic [7:0]    o_red;
    logic [7:0]    o_grn;
    logic [7:0]    o_blu;
    logic [AW:0]   o_level;
    logic          o_synced;
    logic          o_underflow;
    logic          o_frame_err;

    int tests = 0;
    int fails = 0;

    hdmi_pixel_fifo #(
        .DEPTH(DEPTH), .AW(AW), .H_ACTIVE(H), .V_ACTIVE(V), .THRESH(THRESH)
    ) dut (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_sof(i_sof), .i_red(i_red), .i_grn(i_grn), .i_blu(i_blu),
        .i_rd(i_rd), .i_newframe(i_newframe),
        .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_level(o_level),
        .o_synced(o_synced), .o_underflow(o_underflow), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: plain queue of {sof,rgb}, locked flag, frame position.
    logic [24:0] mq[$];
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    bit          m_uf  = 1'b0;
    bit          m_fe  = 1'b0;

    // Compare DUT against the model mid-cycle, then advance the model one clock.
    always @(negedge clk) begin : cmp
        logic [23:0] e_rgb;
        logic [24:0] hd;
        bit          e_pop;
        bit          n_uf;
        bit          n_fe;
        int          sz;
        if (!rst_n) begin
            mq.delete();
            m_run = 1'b0;
            m_cnt = 0;
            m_uf  = 1'b0;
            m_fe  = 1'b0;
            chk("rst_level", 32'(o_level), 0);
            chk("rst_ready", 32'(o_ready), 1);
            chk("rst_synced", 32'(o_synced), 0);
            chk("rst_underflow", 32'(o_underflow), 0);
            chk("rst_frame_err", 32'(o_frame_err), 0);
            chk("rst_rgb", 32'({o_red, o_grn, o_blu}), 0);
        end else begin
            sz    = mq.size();
            hd    = (sz > 0) ? mq[0] : 25'h0;
            e_rgb = 24'h0;
            e_pop = 1'b0;
            n_uf  = 1'b0;
            n_fe  = 1'b0;
            if (m_run && i_rd && sz > 0 && (hd[24] == (m_cnt == 0)))
                e_rgb = hd[23:0];
            chk("level", 32'(o_level), 32'(sz));
            chk("ready", 32'(o_ready), 32'(sz != DEPTH));
            chk("synced", 32'(o_synced), 32'(m_run));
            chk("underflow", 32'(o_underflow), 32'(m_uf));
            chk("frame_err", 32'(o_frame_err), 32'(m_fe));
            chk("rgb", 32'({o_red, o_grn, o_blu}), 32'(e_rgb));
            if (!m_run) begin
                if (sz > 0 && !hd[24]) begin
                    e_pop = 1'b1;
                end else if (i_newframe && sz >= THRESH && hd[24]) begin
                    m_run = 1'b1;
                    m_cnt = 0;
                end
            end else if (i_rd) begin
                if (sz == 0) begin
                    n_uf  = 1'b1;
                    m_run = 1'b0;
                end else if (hd[24] != (m_cnt == 0)) begin
                    n_fe  = 1'b1;
                    m_run = 1'b0;
                end else begin
                    e_pop = 1'b1;
                    m_cnt = (m_cnt + 1) % FRAME;
                end
            end
            if (e_pop) void'(mq.pop_front());
            if (i_valid && sz != DEPTH) mq.push_back({i_sof, i_red, i_grn, i_blu});
            m_uf = n_uf;
            m_fe = n_fe;
        end
    end

    task automatic drive(input bit v, input bit s, input logic [23:0] rgb,
                         input bit rd, input bit nf);
        @(posedge clk);
        #1;
        i_valid    = v;
        i_sof      = s;
        {i_red, i_grn, i_blu} = rgb;
        i_rd       = rd;
        i_newframe = nf;
    endtask

    logic [23:0] px [16];

    initial begin : stim
        int src_cnt;
        bit v;
        bit s;
        bit rd;
        bit nf;
        logic [23:0] rgb;

        // Reset state
        drive(0, 0, 24'h0, 0, 0);
        drive(0, 0, 24'h0, 1, 1);
        #1;
        chk("lit_rst_level", 32'(o_level), 0);
        chk("lit_rst_ready", 32'(o_ready), 1);
        chk("lit_rst_rgb", 32'({o_red, o_grn, o_blu}), 0);
        drive(0, 0, 24'h0, 0, 0);
        rst_n = 1'b1;

        // Fill to full with two SOF-tagged frames; 17th push is refused
        for (int i = 0; i < 16; i++) begin
            px[i] = 24'($urandom);
            drive(1, (i % FRAME) == 0, px[i], 0, 0);
        end
        drive(1, 0, 24'hDEAD01, 0, 0);
        #1;
        chk("lit_full_level", 32'(o_level), 16);
        chk("lit_full_ready", 32'(o_ready), 0);
        chk("lit_full_synced", 32'(o_synced), 0);
        chk("lit_model_full", 32'(mq.size()), 16);
        drive(0, 0, 24'h0, 0, 1);
        #1;
        chk("lit_full_no_17th", 32'(o_level), 16);

        // Lock and drain both frames, then underflow
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 24'h0, 1, 0);
            #1;
            chk("lit_drain_rgb", 32'({o_red, o_grn, o_blu}), 32'(px[i]));
            chk("lit_drain_synced", 32'(o_synced), 1);
        end
        drive(0, 0, 24'h0, 1, 0);
        #1;
        chk("lit_uf_black", 32'({o_red, o_grn, o_blu}), 0);
        drive(0, 0, 24'h0, 0, 0);
        #1;
        chk("lit_uf_pulse", 32'(o_underflow), 1);
        chk("lit_uf_unsync", 32'(o_synced), 0);
        drive(0, 0, 24'h0, 0, 0);
        #1;
        chk("lit_uf_one_cycle", 32'(o_underflow), 0);

        // Lock on a frame of 0x010101..0x080808
        for (int k = 1; k <= 8; k++) drive(1, k == 1, 24'h010101 * k, 0, 0);
        drive(0, 0, 24'h0, 0, 1);
        #1;
        chk("lit_lock_level", 32'(o_level), 8);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 24'h0, 1, 0);
            #1;
            chk("lit_lock_rgb", 32'({o_red, o_grn, o_blu}), 32'(24'h010101 * k));
            chk("lit_lock_synced", 32'(o_synced), 1);
            chk("lit_lock_no_err", 32'(o_frame_err | o_underflow), 0);
        end
        drive(0, 0, 24'h0, 0, 0);
        #1;
        chk("lit_lock_empty", 32'(o_level), 0);

        // Underflow to HUNT, then three stray pixels ahead of a frame
        drive(0, 0, 24'h0, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 24'hAA0000 + 24'(i), 0, 0);
        for (int k = 0; k < 8; k++) drive(1, k == 0, 24'h110000 + 24'(k), 0, 0);
        drive(0, 0, 24'h0, 0, 0);
        drive(0, 0, 24'h0, 0, 0);
        #1;
        chk("lit_hunt_discard3", 32'(o_level), 8);
        chk("lit_hunt_synced", 32'(o_synced), 0);
        drive(0, 0, 24'h0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 24'h0, 1, 0);
            #1;
            chk("lit_hunt_rgb", 32'({o_red, o_grn, o_blu}), 32'(24'h110000 + 24'(k)));
        end

        // Short frame: SOF after 5 pixels
        for (int k = 0; k < 5; k++) drive(1, k == 0, 24'h200000 + 24'(k), 0, 0);
        for (int k = 0; k < 8; k++) drive(1, k == 0, 24'h300000 + 24'(k), 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 24'h0, 1, 0);
            #1;
            chk("lit_short_rgb", 32'({o_red, o_grn, o_blu}),
                (k < 5) ? 32'(24'h200000 + 24'(k)) : 32'h0);
        end
        drive(0, 0, 24'h0, 0, 1);
        #1;
        chk("lit_short_err", 32'(o_frame_err), 1);
        chk("lit_short_unsync", 32'(o_synced), 0);
        chk("lit_short_kept", 32'(o_level), 8);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 24'h0, 1, 0);
            #1;
            chk("lit_relock_rgb", 32'({o_red, o_grn, o_blu}), 32'(24'h300000 + 24'(k)));
        end

        // Reset while locked with 6 entries stored
        for (int k = 0; k < 6; k++) drive(1, k == 0, 24'h400000 + 24'(k), 0, 0);
        drive(0, 0, 24'h0, 0, 0);
        #1;
        chk("lit_pre_rst_level", 32'(o_level), 6);
        chk("lit_pre_rst_synced", 32'(o_synced), 1);
        drive(0, 0, 24'h0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("lit_mid_rst_level", 32'(o_level), 0);
        chk("lit_mid_rst_synced", 32'(o_synced), 0);
        chk("lit_mid_rst_rgb", 32'({o_red, o_grn, o_blu}), 0);
        drive(0, 0, 24'h0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("lit_post_rst_ready", 32'(o_ready), 1);

        // Randomized traffic with occasional short frames and one reset
        src_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            v   = ($urandom % 4) != 0;
            s   = (src_cnt == 0);
            rgb = 24'($urandom);
            rd  = ($urandom % 8) < 5;
            nf  = ($urandom % 10) == 0;
            drive(v, s, rgb, rd, nf);
            if (n == 2000) rst_n = 1'b0;
            if (n == 2002) rst_n = 1'b1;
            if (v && o_ready) begin
                if (($urandom % 20) == 0) src_cnt = 0;
                else src_cnt = (src_cnt + 1) % FRAME;
            end
        end
        drive(0, 0, 24'h0, 0, 0);
        drive(0, 0, 24'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
